vec_csr_diff_source: RTL

Shadow-tracks the architectural vector CSR state from commit-side update events. Emits a snapshot of vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb plus core id per retiring cycle, as the producer end of the vector-CSR difftest channel. A small snapshot FIFO with a valid/ready handshake decouples commit from the downstream difftest sink, which consumes one snapshot per accepted beat.

---
 rtl/vcsr_diff_pkg.sv | 26 ++
 rtl/vcsr_snap_fifo.sv | 54 +++++
 rtl/vec_csr_diff_source.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vcsr_diff_pkg.sv
// Shared types and constants for the vector-CSR difftest source.
package vcsr_diff_pkg;

  // Vector CSR addresses
  localparam logic [11:0] VSTART = 12'h008;
  localparam logic [11:0] VXSAT  = 12'h009;
  localparam logic [11:0] VXRM   = 12'h00A;
  localparam logic [11:0] VCSR   = 12'h00F;
  localparam logic [11:0] VL     = 12'hC20;
  localparam logic [11:0] VTYPE  = 12'hC21;
  localparam logic [11:0] VLENB  = 12'hC22;

  // vtype after reset: vill set, everything else zero
  localparam logic [63:0] VTYPE_RESET = 64'h8000_0000_0000_0000;

  // One queued snapshot; vcsr and vlenb are rebuilt at the output
  typedef struct packed {
    logic [63:0] vstart;
    logic        vxsat;
    logic [1:0]  vxrm;
    logic [63:0] vl;
    logic [63:0] vtype;
    logic [7:0]  coreid;
  } vcsr_snap_t;

endpackage

// File: rtl/vcsr_snap_fifo.sv
// Synchronous snapshot FIFO; head is read straight from storage flops, so
// nothing combinational from the push side reaches it.
module vcsr_snap_fifo
  import vcsr_diff_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  vcsr_snap_t wdata,
  output logic       full,
  input  logic       pop,
  output logic       empty,
  output vcsr_snap_t head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne   = 1;
  localparam logic [PtrW:0]   CountOne = 1;
  localparam logic [PtrW:0]   CountMax = (PtrW+1)'(Depth);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  vcsr_snap_t      mem_q [Depth];
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountMax);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (do_push && !do_pop)      count_q <= count_q + CountOne;
      else if (!do_push && do_pop) count_q <= count_q - CountOne;
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vec_csr_diff_source.sv
// Vector-CSR difftest producer: shadows vstart/vxsat/vxrm/vl/vtype from
// retire-side events and queues one snapshot per committing cycle.
// Optional macro VCSR_DIFF_FILTER_EN: push only snapshots that differ from
// the last one pushed.
module vec_csr_diff_source
  import vcsr_diff_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  io_coreid,
  input  logic        commit_valid,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  input  logic        vset_valid,
  input  logic [63:0] vset_vl,
  input  logic [63:0] vset_vtype,
  input  logic        vxsat_set,
  input  logic        trap_vstart_valid,
  input  logic [63:0] trap_vstart,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_vstart,
  output logic [63:0] out_vxsat,
  output logic [63:0] out_vxrm,
  output logic [63:0] out_vcsr,
  output logic [63:0] out_vl,
  output logic [63:0] out_vtype,
  output logic [63:0] out_vlenb,
  output logic [7:0]  out_coreid,
  output logic        overflow
);

  localparam logic [63:0] VlenbVal = 64'(VLEN / 8);

  logic [63:0] vstart_q, vstart_d, vl_q, vl_d, vtype_q, vtype_d;
  logic        vxsat_q, vxsat_d, vxsat_w;
  logic [1:0]  vxrm_q, vxrm_d;
  logic        overflow_q;
  vcsr_snap_t  snap_d, head;
  logic        full, empty, pop, push_req, push_ok;

  // Next shadow state; later assignments win, giving trap > CSR > vset on vstart
  always_comb begin
    vstart_d = vstart_q;
    vxsat_w  = vxsat_q;
    vxrm_d   = vxrm_q;
    vl_d     = vl_q;
    vtype_d  = vtype_q;
    if (vset_valid) begin
      vl_d     = vset_vl;
      vtype_d  = vset_vtype;
      vstart_d = '0;
    end
    if (csr_wen) begin
      case (csr_addr)
        VSTART: vstart_d = csr_wdata;
        VXSAT:  vxsat_w  = csr_wdata[0];
        VXRM:   vxrm_d   = csr_wdata[1:0];
        VCSR: begin
          vxrm_d  = csr_wdata[2:1];
          vxsat_w = csr_wdata[0];
        end
        default: ;
      endcase
    end
    if (trap_vstart_valid) vstart_d = trap_vstart;
    // Saturation from a retiring op is sticky on top of any write
    vxsat_d = vxsat_w | vxsat_set;
  end

  // Shadow CSR registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vstart_q <= '0;
      vxsat_q  <= 1'b0;
      vxrm_q   <= '0;
      vl_q     <= '0;
      vtype_q  <= VTYPE_RESET;
    end else begin
      vstart_q <= vstart_d;
      vxsat_q  <= vxsat_d;
      vxrm_q   <= vxrm_d;
      vl_q     <= vl_d;
      vtype_q  <= vtype_d;
    end
  end

  assign snap_d = '{vstart: vstart_d, vxsat: vxsat_d, vxrm: vxrm_d,
                    vl: vl_d, vtype: vtype_d, coreid: io_coreid};

  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (~full | pop);

`ifdef VCSR_DIFF_FILTER_EN
  vcsr_snap_t last_q;
  logic       have_last_q;

  assign push_req = commit_valid & (~have_last_q | (snap_d != last_q));

  // Last successfully pushed snapshot, the reference for change detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else if (push_ok) begin
      last_q      <= snap_d;
      have_last_q <= 1'b1;
    end
  end
`else
  assign push_req = commit_valid;
`endif

  // Sticky drop flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else if (push_req && full && !pop) overflow_q <= 1'b1;
  end

  vcsr_snap_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_req),
    .wdata   (snap_d),
    .full    (full),
    .pop     (pop),
    .empty   (empty),
    .head    (head)
  );

  assign out_valid = ~empty;
  assign overflow  = overflow_q;

  // Output fields, forced to zero while nothing is queued
  always_comb begin
    out_vstart = '0;
    out_vxsat  = '0;
    out_vxrm   = '0;
    out_vcsr   = '0;
    out_vl     = '0;
    out_vtype  = '0;
    out_vlenb  = '0;
    out_coreid = '0;
    if (out_valid) begin
      out_vstart = head.vstart;
      out_vxsat  = {63'b0, head.vxsat};
      out_vxrm   = {62'b0, head.vxrm};
      out_vcsr   = {61'b0, head.vxrm, head.vxsat};
      out_vl     = head.vl;
      out_vtype  = head.vtype;
      out_vlenb  = VlenbVal;
      out_coreid = head.coreid;
    end
  end

endmodule
